filter_dpc: RTL and testbench

Datapath controller for the FIR filter unit. Sequences the shared MAC datapath (ALU, accumulator, coefficient and data memories) for each incoming sample. Arbitrates between sample processing and serial coefficient configuration. Sits beside the datapath inside the filter unit and drives `dpc_cmd`, memory addresses and the output-valid strobe.

---
 rtl/myfilter_pkg.sv | 24 ++
 rtl/filter_dpc_addr.sv | 49 ++++
 rtl/filter_dpc.sv | 102 ++++++++++
 tb/tb_filter_dpc.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared types and constants for the FIR filter unit: datapath commands,
// controller states and the default filter geometry.
package myfilter_pkg;

   localparam int FILTER_TAPS = 16;
   localparam int DATABITS    = 16;
   localparam int ACCBITS     = 40;

   typedef enum logic [1:0] {
      DP_NOP = 2'd0,
      DP_CLR = 2'd1,
      DP_MAC = 2'd2,
      DP_OUT = 2'd3
   } dp_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CFG   = 3'd1,
      ST_WRITE = 3'd2,
      ST_MAC   = 3'd3,
      ST_OUT   = 3'd4
   } dpc_state_t;

endpackage

// File: rtl/filter_dpc_addr.sv
// Address generator for the filter controller: owns the circular write
// pointer and the tap counter, and produces coefficient/data addresses.
module filter_dpc_addr
   import myfilter_pkg::*;
#(
   parameter int TAPS = FILTER_TAPS,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  dpc_state_t    state,
   output logic          last_tap,
   output logic [AW-1:0] cmem_addr,
   output logic [AW-1:0] dmem_addr
);

   localparam logic [AW-1:0] LAST    = AW'(TAPS - 1);
   localparam logic [AW-1:0] TAPS_AW = AW'(TAPS);

   logic [AW-1:0] wptr;
   logic [AW-1:0] k;
   logic [AW-1:0] back_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         k    <= '0;
      end else begin
         if (state == ST_MAC)
            k <= (k == LAST) ? '0 : k + 1'b1;
         else
            k <= '0;
         if (state == ST_OUT)
            wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      end
   end

   // Adding TAPS on underflow stays exact in AW bits even when TAPS is not a power of two.
   always_comb begin
      back_addr = wptr - k;
      if (wptr < k)
         back_addr = wptr - k + TAPS_AW;
   end

   assign last_tap  = (k == LAST);
   assign cmem_addr = (state == ST_MAC) ? k : '0;
   assign dmem_addr = (state == ST_MAC) ? back_addr : wptr;

endmodule

// File: rtl/filter_dpc.sv
// FIR datapath controller: arbitrates sample processing against serial
// coefficient configuration. Optional macro FILTER_DPC_OVERRUN_EN adds overrun_out.
module filter_dpc
   import myfilter_pkg::*;
#(
   parameter int TAPS = FILTER_TAPS,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          extready_in,
   input  logic          sde_in,
   input  logic          ul_in,
   input  logic          dl_in,
   output dp_cmd_t       dpc_cmd,
   output logic [AW-1:0] cmem_addr,
   output logic [AW-1:0] dmem_addr,
   output logic          dmem_we,
   output logic          cmem_shift_out,
   output logic          cmem_ul_out,
   output logic          cmem_dl_out,
   output logic          extvalid_out,
   output logic          busy_out
`ifdef FILTER_DPC_OVERRUN_EN
   ,
   output logic          overrun_out
`endif
);

   dpc_state_t state;
   logic       last_tap;

   filter_dpc_addr #(
      .TAPS (TAPS),
      .AW   (AW)
   ) u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state),
      .last_tap  (last_tap),
      .cmem_addr (cmem_addr),
      .dmem_addr (dmem_addr)
   );

   // Requests are only looked at in IDLE; losers of arbitration are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cmem_ul_out  <= 1'b0;
         cmem_dl_out  <= 1'b0;
         extvalid_out <= 1'b0;
      end else begin
         cmem_ul_out  <= 1'b0;
         cmem_dl_out  <= 1'b0;
         extvalid_out <= (state == ST_OUT);
         case (state)
            ST_IDLE: begin
               if (sde_in)
                  state <= ST_CFG;
               else if (extready_in)
                  state <= ST_WRITE;
               else if (ul_in)
                  cmem_ul_out <= 1'b1;
               else if (dl_in)
                  cmem_dl_out <= 1'b1;
            end
            ST_CFG:   if (!sde_in) state <= ST_IDLE;
            ST_WRITE: state <= ST_MAC;
            ST_MAC:   if (last_tap) state <= ST_OUT;
            ST_OUT:   state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dpc_cmd = DP_NOP;
      case (state)
         ST_WRITE: dpc_cmd = DP_CLR;
         ST_MAC:   dpc_cmd = DP_MAC;
         ST_OUT:   dpc_cmd = DP_OUT;
         default:  dpc_cmd = DP_NOP;
      endcase
   end

   assign dmem_we        = (state == ST_WRITE);
   assign cmem_shift_out = (state == ST_CFG);
   assign busy_out       = (state == ST_WRITE) || (state == ST_MAC) || (state == ST_OUT);

`ifdef FILTER_DPC_OVERRUN_EN
   // Sticky flag for samples that were dropped, either busy or outranked by sde_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun_out <= 1'b0;
      else if (extready_in && ((state != ST_IDLE) || sde_in))
         overrun_out <= 1'b1;
      else if ((state == ST_IDLE) && ul_in && !sde_in && !extready_in)
         overrun_out <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_filter_dpc.sv
// Directed self-checking bench for filter_dpc with TAPS=4; overrun checks
// are compiled in when FILTER_DPC_OVERRUN_EN is defined.
module tb_filter_dpc;
   import myfilter_pkg::*;

   localparam int TAPS = 4;
   localparam int AW   = 2;

   logic          clk;
   logic          rst_n;
   logic          extready_in;
   logic          sde_in;
   logic          ul_in;
   logic          dl_in;
   dp_cmd_t       dpc_cmd;
   logic [AW-1:0] cmem_addr;
   logic [AW-1:0] dmem_addr;
   logic          dmem_we;
   logic          cmem_shift_out;
   logic          cmem_ul_out;
   logic          cmem_dl_out;
   logic          extvalid_out;
   logic          busy_out;
`ifdef FILTER_DPC_OVERRUN_EN
   logic          overrun_out;
`endif

   int vectors     = 0;
   int miscompares = 0;

   filter_dpc #(
      .TAPS (TAPS),
      .AW   (AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .extready_in    (extready_in),
      .sde_in         (sde_in),
      .ul_in          (ul_in),
      .dl_in          (dl_in),
      .dpc_cmd        (dpc_cmd),
      .cmem_addr      (cmem_addr),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .cmem_shift_out (cmem_shift_out),
      .cmem_ul_out    (cmem_ul_out),
      .cmem_dl_out    (cmem_dl_out),
      .extvalid_out   (extvalid_out),
      .busy_out       (busy_out)
`ifdef FILTER_DPC_OVERRUN_EN
      ,
      .overrun_out    (overrun_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One full sample from its IDLE cycle 0 to the extvalid cycle; returns without advancing.
   task automatic run_sample(input int e0, input int e1, input int e2, input int e3, input int nxt);
      int exp_d[4];
      exp_d = '{e0, e1, e2, e3};
      extready_in = 1'b1;
      vectors++;
      if (busy_out !== 1'b0 || dpc_cmd !== DP_NOP) begin
         miscompares++;
         $display("[TB] FAIL idle_before_sample: busy=%0d cmd=%0d, expected busy=0 cmd=0", busy_out, dpc_cmd);
      end
      tick();
      extready_in = 1'b0;
      vectors++;
      if (dpc_cmd !== DP_CLR || dmem_we !== 1'b1 || busy_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL write_cycle: cmd=%0d we=%0d busy=%0d, expected cmd=1 we=1 busy=1", dpc_cmd, dmem_we, busy_out);
      end
      vectors++;
      if (dmem_addr !== AW'(e0) || extvalid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL write_addr: dmem=%0d valid=%0d, expected dmem=%0d valid=0", dmem_addr, extvalid_out, e0);
      end
      for (int k = 0; k < TAPS; k++) begin
         tick();
         vectors++;
         if (dpc_cmd !== DP_MAC || dmem_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mac_cmd k=%0d: cmd=%0d we=%0d, expected cmd=2 we=0", k, dpc_cmd, dmem_we);
         end
         vectors++;
         if (cmem_addr !== AW'(k) || dmem_addr !== AW'(exp_d[k])) begin
            miscompares++;
            $display("[TB] FAIL mac_addr k=%0d: cmem=%0d dmem=%0d, expected cmem=%0d dmem=%0d", k, cmem_addr, dmem_addr, k, exp_d[k]);
         end
      end
      tick();
      vectors++;
      if (dpc_cmd !== DP_OUT || extvalid_out !== 1'b0 || busy_out !== 1'b1 || cmem_addr !== 2'd0 || dmem_addr !== AW'(e0)) begin
         miscompares++;
         $display("[TB] FAIL out_cycle: cmd=%0d valid=%0d busy=%0d cmem=%0d dmem=%0d, expected 3 0 1 0 %0d", dpc_cmd, extvalid_out, busy_out, cmem_addr, dmem_addr, e0);
      end
      tick();
      vectors++;
      if (extvalid_out !== 1'b1 || busy_out !== 1'b0 || dpc_cmd !== DP_NOP || dmem_addr !== AW'(nxt)) begin
         miscompares++;
         $display("[TB] FAIL valid_cycle: valid=%0d busy=%0d cmd=%0d dmem=%0d, expected 1 0 0 %0d", extvalid_out, busy_out, dpc_cmd, dmem_addr, nxt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      extready_in = 1'b0;
      sde_in = 1'b0;
      ul_in = 1'b0;
      dl_in = 1'b0;
      idle(2);
      vectors++;
      if (dpc_cmd !== DP_NOP || cmem_addr !== 2'd0 || dmem_addr !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_cmd_addr: cmd=%0d cmem=%0d dmem=%0d, expected all 0", dpc_cmd, cmem_addr, dmem_addr);
      end
      vectors++;
      if ({dmem_we, cmem_shift_out, cmem_ul_out, cmem_dl_out, extvalid_out, busy_out} !== 6'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b, expected 000000", {dmem_we, cmem_shift_out, cmem_ul_out, cmem_dl_out, extvalid_out, busy_out});
      end
`ifdef FILTER_DPC_OVERRUN_EN
      vectors++;
      if (overrun_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_overrun: got %0d, expected 0", overrun_out);
      end
`endif
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_single_and_wrap();
      run_sample(0, 3, 2, 1, 1);
      idle(2);
      run_sample(1, 0, 3, 2, 2);
      idle(1);
      run_sample(2, 1, 0, 3, 3);
      idle(1);
      run_sample(3, 2, 1, 0, 0);
      idle(1);
      run_sample(0, 3, 2, 1, 1);
      idle(1);
      run_sample(1, 0, 3, 2, 2);
      idle(2);
   endtask

   task automatic test_config();
      int  shifts = 0;
      int  first  = -1;
      bit  saw_busy = 1'b0;
      bit  saw_cmd  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         sde_in      = (c < 8);
         extready_in = (c == 3);
         if (cmem_shift_out === 1'b1) begin
            shifts++;
            if (first < 0) first = c;
         end
         if (dmem_we !== 1'b0 || busy_out !== 1'b0) saw_busy = 1'b1;
         if (dpc_cmd !== DP_NOP) saw_cmd = 1'b1;
         tick();
      end
      extready_in = 1'b0;
      vectors++;
      if (shifts != 8 || first != 1) begin
         miscompares++;
         $display("[TB] FAIL cfg_shift: count=%0d first=%0d, expected count=8 first=1", shifts, first);
      end
      vectors++;
      if (saw_busy || saw_cmd) begin
         miscompares++;
         $display("[TB] FAIL cfg_no_write: busy_seen=%0d cmd_seen=%0d, expected 0 0", saw_busy, saw_cmd);
      end
`ifdef FILTER_DPC_OVERRUN_EN
      vectors++;
      if (overrun_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL cfg_overrun: got %0d, expected 1", overrun_out);
      end
`endif
   endtask

   task automatic test_upload_download();
      ul_in = 1'b1;
      tick();
      ul_in = 1'b0;
      vectors++;
      if (cmem_ul_out !== 1'b1 || cmem_dl_out !== 1'b0 || busy_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ul_pulse: ul=%0d dl=%0d busy=%0d, expected 1 0 0", cmem_ul_out, cmem_dl_out, busy_out);
      end
`ifdef FILTER_DPC_OVERRUN_EN
      vectors++;
      if (overrun_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ul_clears_overrun: got %0d, expected 0", overrun_out);
      end
`endif
      tick();
      vectors++;
      if (cmem_ul_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ul_one_cycle: got %0d, expected 0", cmem_ul_out);
      end
      dl_in = 1'b1;
      tick();
      dl_in = 1'b0;
      vectors++;
      if (cmem_dl_out !== 1'b1 || cmem_ul_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL dl_pulse: dl=%0d ul=%0d, expected 1 0", cmem_dl_out, cmem_ul_out);
      end
      tick();
      ul_in = 1'b1;
      dl_in = 1'b1;
      vectors++;
      if (cmem_dl_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL dl_one_cycle: got %0d, expected 0", cmem_dl_out);
      end
      tick();
      ul_in = 1'b0;
      dl_in = 1'b0;
      vectors++;
      if (cmem_ul_out !== 1'b1 || cmem_dl_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ul_over_dl: ul=%0d dl=%0d, expected 1 0", cmem_ul_out, cmem_dl_out);
      end
      idle(1);
   endtask

   task automatic test_arbitration();
      sde_in = 1'b1;
      extready_in = 1'b1;
      ul_in = 1'b1;
      tick();
      sde_in = 1'b0;
      extready_in = 1'b0;
      ul_in = 1'b0;
      vectors++;
      if (cmem_shift_out !== 1'b1 || dmem_we !== 1'b0 || cmem_ul_out !== 1'b0 || busy_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL arb_cfg_wins: shift=%0d we=%0d ul=%0d busy=%0d, expected 1 0 0 0", cmem_shift_out, dmem_we, cmem_ul_out, busy_out);
      end
      tick();
      vectors++;
      if (cmem_shift_out !== 1'b0 || busy_out !== 1'b0 || cmem_ul_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL arb_back_idle: shift=%0d busy=%0d ul=%0d, expected 0 0 0", cmem_shift_out, busy_out, cmem_ul_out);
      end
`ifdef FILTER_DPC_OVERRUN_EN
      vectors++;
      if (overrun_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL arb_overrun: got %0d, expected 1", overrun_out);
      end
`endif
      ul_in = 1'b1;
      tick();
      ul_in = 1'b0;
      idle(1);
   endtask

   task automatic test_back_to_back();
      run_sample(2, 1, 0, 3, 3);
      run_sample(3, 2, 1, 0, 0);
      tick();
      vectors++;
      if (extvalid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_valid_single: got %0d, expected 0", extvalid_out);
      end
`ifdef FILTER_DPC_OVERRUN_EN
      vectors++;
      if (overrun_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_no_overrun: got %0d, expected 0", overrun_out);
      end
`endif
      idle(1);
   endtask

   task automatic test_reset_mid_mac();
      bit saw_valid = 1'b0;
      extready_in = 1'b1;
      tick();
      extready_in = 1'b0;
      idle(2);
      vectors++;
      if (dpc_cmd !== DP_MAC) begin
         miscompares++;
         $display("[TB] FAIL pre_reset_mac: cmd=%0d, expected 2", dpc_cmd);
      end
      rst_n = 1'b0;
      tick();
      vectors++;
      if (dpc_cmd !== DP_NOP || cmem_addr !== 2'd0 || dmem_addr !== 2'd0 || busy_out !== 1'b0 || extvalid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_mac_reset: cmd=%0d cmem=%0d dmem=%0d busy=%0d valid=%0d, expected all 0", dpc_cmd, cmem_addr, dmem_addr, busy_out, extvalid_out);
      end
      for (int c = 0; c < 8; c++) begin
         if (c == 1) rst_n = 1'b1;
         if (extvalid_out !== 1'b0 || busy_out !== 1'b0) saw_valid = 1'b1;
         tick();
      end
      vectors++;
      if (saw_valid) begin
         miscompares++;
         $display("[TB] FAIL reset_discards: valid or busy seen after reset, expected none");
      end
   endtask

   initial begin
      $display("[TB] filter_dpc bench start, TAPS=%0d", TAPS);
      test_reset();
      test_single_and_wrap();
      test_config();
      test_upload_download();
      test_arbitration();
      test_back_to_back();
      test_reset_mid_mac();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
